// File: rtl/stopwatch_lap_timer.sv
// -----------------------------------------------------------------------------
// stopwatch_lap_timer
//
// MM:SS stopwatch with a tick prescaler, optional count-down (timer) mode with
// a one-cycle expiry pulse, and a small show-ahead FIFO of captured lap times.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, stop           start/resume and pause pulses
//   reset                 synchronous soft clear of count, state, mode, lap FIFO
//   count_down            mode select, sampled when start is accepted in IDLE
//   load, load_min/sec    preload the count while IDLE (seconds clamped to 59)
//   lap, lap_rd           push current time / pop FIFO head
//   minutes, seconds      current count
//   status                00 IDLE, 01 RUNNING, 10 PAUSED, 11 EXPIRED
//   expired               one-cycle pulse on entering EXPIRED
//   lap_valid, lap_min/sec, lap_count, lap_overflow   lap FIFO view
// -----------------------------------------------------------------------------
module stopwatch_lap_timer #(
  parameter int TICK_DIV  = 1,
  parameter int MIN_W     = 8,
  parameter int LAP_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           stop,
  input  logic                           reset,
  input  logic                           count_down,
  input  logic                           load,
  input  logic [MIN_W-1:0]               load_min,
  input  logic [5:0]                     load_sec,
  input  logic                           lap,
  input  logic                           lap_rd,
  output logic [MIN_W-1:0]               minutes,
  output logic [5:0]                     seconds,
  output logic [1:0]                     status,
  output logic                           expired,
  output logic                           lap_valid,
  output logic [MIN_W-1:0]               lap_min,
  output logic [5:0]                     lap_sec,
  output logic [$clog2(LAP_DEPTH+1)-1:0] lap_count,
  output logic                           lap_overflow
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int PTR_W = $clog2(LAP_DEPTH);
  localparam int CNT_W = $clog2(LAP_DEPTH + 1);
  localparam int ENT_W = MIN_W + 6;
  localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(LAP_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUNNING = 2'b01,
    ST_PAUSED  = 2'b10,
    ST_EXPIRED = 2'b11
  } state_e;

  state_e             state_q, state_d;
  logic               mode_q, mode_d;
  logic [PRE_W-1:0]   presc_q, presc_d;
  logic [MIN_W-1:0]   min_q, min_d;
  logic [5:0]         sec_q, sec_d;
  logic               expired_q, expired_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [ENT_W-1:0]   mem_q [LAP_DEPTH];
  logic [ENT_W-1:0]   mem_d [LAP_DEPTH];

  // Control decode. A stop (or soft reset) in a RUNNING cycle freezes the
  // prescaler and count on that edge, so a pause never swallows a tick.
  logic run_cycle, tick, idle_start, load_ok, expire_now;
  logic push_req, push_en, pop_en, fifo_full;
  logic [ENT_W-1:0] head;

  always_comb begin
    run_cycle  = (state_q == ST_RUNNING) && !reset && !stop;
    tick       = run_cycle && (presc_q == PRE_MAX);
    idle_start = (state_q == ST_IDLE) && start && !stop && !reset &&
                 !(count_down && (min_q == '0) && (sec_q == 6'd0));
    load_ok    = (state_q == ST_IDLE) && load && !start && !stop && !reset;
    expire_now = tick && mode_q && (min_q == '0) && (sec_q == 6'd1);
  end

  // State register and all datapath flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mode_q    <= 1'b0;
      presc_q   <= '0;
      min_q     <= '0;
      sec_q     <= '0;
      expired_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      mem_q     <= '{default: '0};
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      presc_q   <= presc_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      expired_q <= expired_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      mem_q     <= mem_d;
    end
  end

  // Next-state logic: reset > stop > start.
  always_comb begin
    state_d = state_q;
    if (reset) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:    if (idle_start) state_d = ST_RUNNING;
        ST_RUNNING: begin
          if (stop)            state_d = ST_PAUSED;
          else if (expire_now) state_d = ST_EXPIRED;
        end
        ST_PAUSED:  if (!stop && start) state_d = ST_RUNNING;
        ST_EXPIRED: state_d = ST_EXPIRED;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // Count, mode and prescaler.
  always_comb begin
    mode_d    = mode_q;
    presc_d   = presc_q;
    min_d     = min_q;
    sec_d     = sec_q;
    expired_d = (state_q != ST_EXPIRED) && (state_d == ST_EXPIRED);
    if (reset) begin
      mode_d  = 1'b0;
      presc_d = '0;
      min_d   = '0;
      sec_d   = '0;
    end else if (idle_start) begin
      mode_d  = count_down;
      presc_d = '0;
    end else if (load_ok) begin
      min_d = load_min;
      sec_d = (load_sec > 6'd59) ? 6'd59 : load_sec;
    end else if (tick) begin
      presc_d = '0;
      if (!mode_q) begin
        // Up count wraps (2^MIN_W-1):59 -> 00:00 through natural overflow.
        if (sec_q == 6'd59) begin
          sec_d = 6'd0;
          min_d = min_q + 1'b1;
        end else begin
          sec_d = sec_q + 6'd1;
        end
      end else begin
        if (sec_q == 6'd0) begin
          sec_d = 6'd59;
          min_d = min_q - 1'b1;
        end else begin
          sec_d = sec_q - 6'd1;
        end
      end
    end else if (run_cycle) begin
      presc_d = presc_q + 1'b1;
    end
  end

  // Lap FIFO. A push when full only succeeds if a pop frees the slot on the
  // same edge; a pop on an empty FIFO is ignored.
  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    fifo_full = (cnt_q == CNT_FULL);
    pop_en    = lap_rd && (cnt_q != '0);
    push_req  = lap && ((state_q == ST_RUNNING) || (state_q == ST_PAUSED));
    push_en   = push_req && (!fifo_full || pop_en);
    if (reset) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push_en) begin
        mem_d[wr_ptr_q] = {min_q, sec_q};
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop_en) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push_en && !pop_en) begin
        cnt_d = cnt_q + 1'b1;
      end else if (!push_en && pop_en) begin
        cnt_d = cnt_q - 1'b1;
      end
      if (push_req && fifo_full && !pop_en) begin
        ovf_d = 1'b1;
      end
    end
  end

  // Outputs; lap head is show-ahead and forced to zero while empty.
  always_comb begin
    head         = mem_q[rd_ptr_q];
    minutes      = min_q;
    seconds      = sec_q;
    status       = state_q;
    expired      = expired_q;
    lap_valid    = (cnt_q != '0);
    lap_min      = lap_valid ? head[ENT_W-1:6] : '0;
    lap_sec      = lap_valid ? head[5:0] : 6'd0;
    lap_count    = cnt_q;
    lap_overflow = ovf_q;
  end

endmodule

// File: tb/tb_stopwatch_lap_timer.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_lap_timer
//
// Drives two stopwatch instances from shared stimulus: A (TICK_DIV=1, MIN_W=2)
// and B (TICK_DIV=4, MIN_W=8). Each instance is predicted by a reference model
// that keeps the time as a total-seconds integer and the lap FIFO as a queue.
// -----------------------------------------------------------------------------
module tb_stopwatch_lap_timer;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, stop = 1'b0, reset = 1'b0, countDown = 1'b0;
  logic load = 1'b0, lap = 1'b0, lapRd = 1'b0;
  logic [7:0] loadMin = 8'd0;
  logic [5:0] loadSec = 6'd0;
  logic [1:0] aLoadMin;

  logic [1:0] aMinutes, aLapMin;
  logic [5:0] aSeconds, aLapSec;
  logic [1:0] aStatus;
  logic       aExpired, aLapValid, aLapOverflow;
  logic [2:0] aLapCount;

  logic [7:0] bMinutes, bLapMin;
  logic [5:0] bSeconds, bLapSec;
  logic [1:0] bStatus;
  logic       bExpired, bLapValid, bLapOverflow;
  logic [2:0] bLapCount;

  assign aLoadMin = loadMin[1:0];

  stopwatch_lap_timer #(.TICK_DIV(1), .MIN_W(2), .LAP_DEPTH(DEPTH)) dutA (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .reset(reset),
    .count_down(countDown), .load(load), .load_min(aLoadMin), .load_sec(loadSec),
    .lap(lap), .lap_rd(lapRd), .minutes(aMinutes), .seconds(aSeconds),
    .status(aStatus), .expired(aExpired), .lap_valid(aLapValid),
    .lap_min(aLapMin), .lap_sec(aLapSec), .lap_count(aLapCount),
    .lap_overflow(aLapOverflow)
  );

  stopwatch_lap_timer #(.TICK_DIV(4), .MIN_W(8), .LAP_DEPTH(DEPTH)) dutB (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .reset(reset),
    .count_down(countDown), .load(load), .load_min(loadMin), .load_sec(loadSec),
    .lap(lap), .lap_rd(lapRd), .minutes(bMinutes), .seconds(bSeconds),
    .status(bStatus), .expired(bExpired), .lap_valid(bLapValid),
    .lap_min(bLapMin), .lap_sec(bLapSec), .lap_count(bLapCount),
    .lap_overflow(bLapOverflow)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // st: 0 idle, 1 running, 2 paused, 3 expired; t: total seconds shown.
  typedef struct {
    int st;
    bit down;
    int pre;
    int t;
    bit exp;
    bit ovf;
  } model_t;

  model_t mdl [2];
  int lapQA[$];
  int lapQB[$];
  int tickDiv [2] = '{1, 4};
  int minMod  [2] = '{4, 256};

  // Clears both reference models to their power-on state.
  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      mdl[k].st = 0; mdl[k].down = 1'b0; mdl[k].pre = 0;
      mdl[k].t = 0; mdl[k].exp = 1'b0; mdl[k].ovf = 1'b0;
    end
    lapQA.delete();
    lapQB.delete();
  endtask

  // Advances one model across a clock edge using the currently driven inputs.
  task automatic modelStep(input int k);
    model_t m;
    int q[$];
    bit pop, push, full;
    m = mdl[k];
    if (k == 0) q = lapQA; else q = lapQB;
    m.exp = 1'b0;
    if (reset) begin
      q.delete();
      m.ovf = 1'b0; m.st = 0; m.t = 0; m.down = 1'b0; m.pre = 0;
    end else begin
      full = (q.size() == DEPTH);
      pop  = lapRd && (q.size() > 0);
      push = lap && (m.st == 1 || m.st == 2);
      if (pop) void'(q.pop_front());
      if (push) begin
        if (full && !pop) m.ovf = 1'b1;
        else q.push_back(m.t);
      end
      case (m.st)
        0: begin
          if (!stop) begin
            if (start) begin
              if (!(countDown && m.t == 0)) begin
                m.st = 1; m.down = countDown; m.pre = 0;
              end
            end else if (load) begin
              m.t = (int'(loadMin) % minMod[k]) * 60 +
                    ((loadSec > 6'd59) ? 59 : int'(loadSec));
            end
          end
        end
        1: begin
          if (stop) begin
            m.st = 2;
          end else begin
            m.pre++;
            if (m.pre == tickDiv[k]) begin
              m.pre = 0;
              if (!m.down) begin
                m.t = (m.t + 1) % (minMod[k] * 60);
              end else begin
                m.t--;
                if (m.t == 0) begin
                  m.st = 3; m.exp = 1'b1;
                end
              end
            end
          end
        end
        2: if (!stop && start) m.st = 1;
        default: ;
      endcase
    end
    mdl[k] = m;
    if (k == 0) lapQA = q; else lapQB = q;
  endtask

  // Single comparison point.
  task automatic checkValue(input string tag, input int obs, input int expVal);
    checks++;
    assert (obs === expVal) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expVal);
    end
  endtask

  // Compares every output of both instances against the models.
  task automatic checkOutput();
    int q[$];
    int oMin, oSec, oSt, oExp, oVal, oLMin, oLSec, oCnt, oOvf;
    string p;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin
        q = lapQA; p = "A";
        oMin = int'(aMinutes); oSec = int'(aSeconds); oSt = int'(aStatus);
        oExp = int'(aExpired); oVal = int'(aLapValid); oLMin = int'(aLapMin);
        oLSec = int'(aLapSec); oCnt = int'(aLapCount); oOvf = int'(aLapOverflow);
      end else begin
        q = lapQB; p = "B";
        oMin = int'(bMinutes); oSec = int'(bSeconds); oSt = int'(bStatus);
        oExp = int'(bExpired); oVal = int'(bLapValid); oLMin = int'(bLapMin);
        oLSec = int'(bLapSec); oCnt = int'(bLapCount); oOvf = int'(bLapOverflow);
      end
      checkValue({p, "_minutes"}, oMin, mdl[k].t / 60);
      checkValue({p, "_seconds"}, oSec, mdl[k].t % 60);
      checkValue({p, "_status"}, oSt, mdl[k].st);
      checkValue({p, "_expired"}, oExp, int'(mdl[k].exp));
      checkValue({p, "_lap_valid"}, oVal, (q.size() > 0) ? 1 : 0);
      checkValue({p, "_lap_min"}, oLMin, (q.size() > 0) ? q[0] / 60 : 0);
      checkValue({p, "_lap_sec"}, oLSec, (q.size() > 0) ? q[0] % 60 : 0);
      checkValue({p, "_lap_count"}, oCnt, q.size());
      checkValue({p, "_lap_overflow"}, oOvf, int'(mdl[k].ovf));
    end
  endtask

  // One clock edge with the current inputs, then pulses drop and outputs are checked.
  task automatic applyStimulus();
    modelStep(0);
    modelStep(1);
    @(posedge clk);
    #1;
    start = 1'b0; stop = 1'b0; reset = 1'b0; load = 1'b0; lap = 1'b0; lapRd = 1'b0;
    checkOutput();
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  initial begin
    int guard;
    $display("[TB] stopwatch_lap_timer bench starting");
    modelReset();
    #2;
    checkOutput();
    #1 rst_n = 1'b1;

    // Basic run / pause / resume on A.
    start = 1'b1; applyStimulus();
    idleCycles(5);
    checkValue("A_run5_sec", int'(aSeconds), 5);
    checkValue("A_run5_status", int'(aStatus), 1);
    stop = 1'b1; applyStimulus();
    idleCycles(2);
    checkValue("A_pause_sec", int'(aSeconds), 5);
    checkValue("A_pause_status", int'(aStatus), 2);
    start = 1'b1; applyStimulus();
    applyStimulus();
    checkValue("A_resume_sec", int'(aSeconds), 6);
    reset = 1'b1; applyStimulus();
    checkValue("A_softreset_status", int'(aStatus), 0);

    // Prescaler preservation across a pause on B.
    start = 1'b1; applyStimulus();
    idleCycles(12);
    checkValue("B_div4_sec", int'(bSeconds), 3);
    idleCycles(2);
    stop = 1'b1; applyStimulus();
    idleCycles(10);
    start = 1'b1; applyStimulus();
    applyStimulus();
    checkValue("B_presc_hold_sec", int'(bSeconds), 3);
    applyStimulus();
    checkValue("B_presc_tick_sec", int'(bSeconds), 4);

    // Up rollover on A (MIN_W=2), carry and load clamp.
    reset = 1'b1; applyStimulus();
    loadMin = 8'd3; loadSec = 6'd58; load = 1'b1; applyStimulus();
    start = 1'b1; applyStimulus();
    applyStimulus();
    checkValue("A_roll_min", int'(aMinutes), 3);
    applyStimulus();
    checkValue("A_wrap_sec", int'(aSeconds), 0);
    checkValue("A_wrap_min", int'(aMinutes), 0);
    checkValue("A_wrap_status", int'(aStatus), 1);
    reset = 1'b1; applyStimulus();
    loadMin = 8'd0; loadSec = 6'd59; load = 1'b1; applyStimulus();
    start = 1'b1; applyStimulus();
    applyStimulus();
    checkValue("A_carry_min", int'(aMinutes), 1);
    reset = 1'b1; applyStimulus();
    loadMin = 8'd2; loadSec = 6'd62; load = 1'b1; applyStimulus();
    checkValue("A_clamp_sec", int'(aSeconds), 59);

    // Count-down to expiry.
    reset = 1'b1; applyStimulus();
    countDown = 1'b1; loadMin = 8'd1; loadSec = 6'd1; load = 1'b1; applyStimulus();
    start = 1'b1; applyStimulus();
    idleCycles(61);
    checkValue("A_expire_status", int'(aStatus), 3);
    checkValue("A_expire_pulse", int'(aExpired), 1);
    applyStimulus();
    checkValue("A_expire_pulse_end", int'(aExpired), 0);
    start = 1'b1; applyStimulus();
    checkValue("A_expired_hold", int'(aStatus), 3);
    reset = 1'b1; applyStimulus();
    start = 1'b1; applyStimulus();
    checkValue("A_down_zero_start", int'(aStatus), 0);
    countDown = 1'b0;

    // Lap FIFO fill, overflow and drain.
    start = 1'b1; applyStimulus();
    for (int i = 0; i < 12; i++) begin
      lap = (mdl[0].t inside {2, 4, 6, 8, 10});
      applyStimulus();
    end
    checkValue("A_lap_full_count", int'(aLapCount), 4);
    checkValue("A_lap_overflow", int'(aLapOverflow), 1);
    checkValue("A_lap_head", int'(aLapSec), 2);
    for (int i = 0; i < 4; i++) begin
      checkValue("A_lap_pop_sec", int'(aLapSec), 2 * (i + 1));
      lapRd = 1'b1; applyStimulus();
    end
    checkValue("A_lap_drained", int'(aLapValid), 0);
    reset = 1'b1; applyStimulus();
    start = 1'b1; applyStimulus();
    for (int i = 0; i < 4; i++) begin
      lap = 1'b1; applyStimulus();
    end
    lap = 1'b1; lapRd = 1'b1; applyStimulus();
    checkValue("A_pushpop_count", int'(aLapCount), 4);
    checkValue("A_pushpop_ovf", int'(aLapOverflow), 0);

    // Asynchronous reset mid-run with laps queued.
    reset = 1'b1; applyStimulus();
    start = 1'b1; applyStimulus();
    guard = 0;
    while (mdl[0].t != 7 && guard < 20) begin
      lap = (mdl[0].t == 3) || (mdl[0].t == 5);
      applyStimulus();
      guard++;
    end
    checkValue("A_reach_7", mdl[0].t, 7);
    checkValue("A_async_pre_laps", int'(aLapCount), 2);
    #2 rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput();
    checkValue("A_async_sec", int'(aSeconds), 0);
    #1 rst_n = 1'b1;
    start = 1'b1; applyStimulus();
    applyStimulus();
    checkValue("A_after_async_sec", int'(aSeconds), 1);

    // Randomized traffic against the models.
    for (int i = 0; i < 400; i++) begin
      reset     = ($urandom_range(0, 39) == 0);
      stop      = ($urandom_range(0, 7) == 0);
      start     = ($urandom_range(0, 5) == 0);
      load      = ($urandom_range(0, 7) == 0);
      countDown = 1'($urandom_range(0, 1));
      loadMin   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                              : 8'($urandom_range(0, 1));
      loadSec   = 6'($urandom_range(0, 63));
      lap       = ($urandom_range(0, 3) == 0);
      lapRd     = ($urandom_range(0, 3) == 0);
      applyStimulus();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
